// File: rtl/game_pkg.sv
// Shared game constants and types used by the projectile controller and collisions.
package game_pkg;

    localparam int SCREEN_W             = 1024;
    localparam int SCREEN_H             = 768;

    localparam int PLAYER_YPOS          = 700;
    localparam int PLAYER_WIDTH         = 64;
    localparam int PROJECTILE_WIDTH     = 16;
    localparam int PROJECTILE_HEIGHT    = 32;

    localparam int PROJ_SPEED           = 8;
    localparam int PROJ_TOP_LIMIT       = 0;
    localparam int PROJ_COOLDOWN_FRAMES = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } projectile_state_t;

    // Bullet left edge centred on the player cannon, wrapping mod 4096.
    function automatic logic [11:0] launch_xpos(input logic [11:0] player_x,
                                                input int player_w,
                                                input int proj_w);
        return player_x + 12'((player_w - proj_w) / 2);
    endfunction

endpackage

// File: rtl/player_projectile.sv
// Player bullet controller: launches on fire, climbs SPEED px per frame,
// retires on bullet_hit or at the screen top, then waits COOLDOWN_FRAMES.
// Build option: define PROJECTILE_AUTOFIRE_EN to launch on fire level
// instead of a rising edge.
module player_projectile #(
    parameter int PLAYER_YPOS       = game_pkg::PLAYER_YPOS,
    parameter int PLAYER_WIDTH      = game_pkg::PLAYER_WIDTH,
    parameter int PROJECTILE_WIDTH  = game_pkg::PROJECTILE_WIDTH,
    parameter int PROJECTILE_HEIGHT = game_pkg::PROJECTILE_HEIGHT,
    parameter int SPEED             = game_pkg::PROJ_SPEED,
    parameter int TOP_LIMIT         = game_pkg::PROJ_TOP_LIMIT,
    parameter int COOLDOWN_FRAMES   = game_pkg::PROJ_COOLDOWN_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic [11:0] player_xpos,
    input  logic        bullet_hit,
    output logic [11:0] projectile_xpos,
    output logic [11:0] projectile_ypos,
    output logic        bullet_active,
    output logic        shot_fired
);
    import game_pkg::*;

    localparam logic [11:0] LAUNCH_Y = 12'(PLAYER_YPOS - PROJECTILE_HEIGHT);
    localparam logic [11:0] SPEED_Y  = 12'(SPEED);
    // Any ypos below this would step past TOP_LIMIT, so the bullet retires instead.
    localparam logic [11:0] RETIRE_Y = 12'(TOP_LIMIT + SPEED);
    localparam logic [15:0] CD_LIMIT = 16'(COOLDOWN_FRAMES);

    projectile_state_t state_q, state_d;
    logic [11:0]       xpos_q, xpos_d;
    logic [11:0]       ypos_q, ypos_d;
    logic              active_q, active_d;
    logic              shot_q, shot_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              fire_hist_q, fire_hist_d;
    logic              launch_req;

`ifdef PROJECTILE_AUTOFIRE_EN
    assign launch_req = fire;
`else
    assign launch_req = fire & ~fire_hist_q;
`endif

    // Next-state and next-output logic for the launch / flight / cooldown cycle.
    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        active_d    = active_q;
        shot_d      = 1'b0;
        cnt_d       = cnt_q;
        fire_hist_d = fire;
        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (launch_req) begin
                    xpos_d   = launch_xpos(player_xpos, PLAYER_WIDTH, PROJECTILE_WIDTH);
                    ypos_d   = LAUNCH_Y;
                    active_d = 1'b1;
                    shot_d   = 1'b1;
                    state_d  = FLYING;
                end
            end
            FLYING: begin
                if (bullet_hit) begin
                    active_d = 1'b0;
                    cnt_d    = 16'd0;
                    state_d  = COOLDOWN;
                end else if (frame_tick) begin
                    if (ypos_q < RETIRE_Y) begin
                        active_d = 1'b0;
                        cnt_d    = 16'd0;
                        state_d  = COOLDOWN;
                    end else begin
                        ypos_d = ypos_q - SPEED_Y;
                    end
                end
            end
            COOLDOWN: begin
                active_d = 1'b0;
                if (cnt_q == CD_LIMIT) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset parks the bullet at the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xpos_q      <= 12'd0;
            ypos_q      <= 12'd0;
            active_q    <= 1'b0;
            shot_q      <= 1'b0;
            cnt_q       <= 16'd0;
            fire_hist_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            active_q    <= active_d;
            shot_q      <= shot_d;
            cnt_q       <= cnt_d;
            fire_hist_q <= fire_hist_d;
        end
    end

    assign projectile_xpos = xpos_q;
    assign projectile_ypos = ypos_q;
    assign bullet_active   = active_q;
    assign shot_fired      = shot_q;

endmodule

// File: tb/tb_player_projectile.sv
// Self-checking bench for player_projectile: directed scenarios followed by
// random traffic, every cycle compared against a behavioural bullet model.
module tb_player_projectile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        fire = 1'b0;
    logic        bullet_hit = 1'b0;
    logic [11:0] player_xpos = 12'd500;
    logic [11:0] projectile_xpos;
    logic [11:0] projectile_ypos;
    logic        bullet_active;
    logic        shot_fired;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: a bullet is either in the air, locked out for a
    // number of remaining frames (plus one settling cycle), or ready.
    bit m_in_air;
    bit m_locked;
    int m_frames_left;
    bit m_shot;
    bit m_prev_fire;
    int m_x;
    int m_y;

    player_projectile dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .fire            (fire),
        .player_xpos     (player_xpos),
        .bullet_hit      (bullet_hit),
        .projectile_xpos (projectile_xpos),
        .projectile_ypos (projectile_ypos),
        .bullet_active   (bullet_active),
        .shot_fired      (shot_fired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit want;
        if (rst) begin
            m_in_air = 0; m_locked = 0; m_frames_left = 0; m_shot = 0;
            m_prev_fire = 0; m_x = 0; m_y = 0;
            return;
        end
`ifdef PROJECTILE_AUTOFIRE_EN
        want = fire;
`else
        want = fire && !m_prev_fire;
`endif
        m_shot = 0;
        if (m_in_air) begin
            if (bullet_hit) begin
                m_in_air = 0; m_locked = 1; m_frames_left = 15;
            end else if (frame_tick) begin
                if (m_y - 8 < 0) begin
                    m_in_air = 0; m_locked = 1; m_frames_left = 15;
                end else begin
                    m_y = m_y - 8;
                end
            end
        end else if (m_locked) begin
            if (m_frames_left == 0) m_locked = 0;
            else if (frame_tick) m_frames_left--;
        end else if (want) begin
            m_in_air = 1;
            m_shot   = 1;
            m_x      = (int'(player_xpos) + (64 - 16) / 2) % 4096;
            m_y      = 700 - 32;
        end
        m_prev_fire = fire;
    endtask

    // One clock: apply inputs, advance model, check all outputs after the edge.
    task automatic cyc(input bit f, input bit t, input bit h, input bit r);
        fire = f; frame_tick = t; bullet_hit = h; rst = r;
        @(posedge clk);
        model_step();
        #1;
        chk("xpos",   projectile_xpos, 12'(m_x));
        chk("ypos",   projectile_ypos, 12'(m_y));
        chk("active", {11'd0, bullet_active}, {11'd0, m_in_air});
        chk("shot",   {11'd0, shot_fired}, {11'd0, m_shot});
    endtask

    initial begin
        int guard;
        bit f;

        // 1: reset state, then launch from x=500
        player_xpos = 12'd500;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_x", projectile_xpos, 12'd0);
        chk("rst_y", projectile_ypos, 12'd0);
        chk("rst_active", {11'd0, bullet_active}, 12'd0);
        chk("rst_shot", {11'd0, shot_fired}, 12'd0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t1_x", projectile_xpos, 12'd524);
        chk("t1_y", projectile_ypos, 12'd668);
        chk("t1_active", {11'd0, bullet_active}, 12'd1);
        chk("t1_shot", {11'd0, shot_fired}, 12'd1);
        cyc(1, 0, 0, 0);
        chk("t1_shot_once", {11'd0, shot_fired}, 12'd0);
        $display("step 1 launch: x=%0d y=%0d", projectile_xpos, projectile_ypos);

        // 2: ten frame ticks, then idle cycles hold position
        repeat (10) cyc(1, 1, 0, 0);
        chk("t2_y10", projectile_ypos, 12'd588);
        repeat (3) cyc(1, 0, 0, 0);
        chk("t2_hold", projectile_ypos, 12'd588);
        $display("step 2 flight: y=%0d", projectile_ypos);

        // 3: hit wins over a coincident frame tick
        cyc(1, 1, 1, 0);
        chk("t3_active", {11'd0, bullet_active}, 12'd0);
        chk("t3_y", projectile_ypos, 12'd588);
        $display("step 3 hit: active=%0d y=%0d", bullet_active, projectile_ypos);

        guard = 0;
        while (m_locked && guard < 100) begin
            cyc(0, 1, 0, 0);
            guard++;
        end
        if (guard >= 100) begin
            n_fail++;
            $error("FAIL cooldown_bound: observed %0d cycles expected < 100", guard);
        end

        // 4: climb to the top, retire, cooldown drops a mid-cooldown fire edge
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t4_launch", {11'd0, bullet_active}, 12'd1);
        guard = 0;
        while (m_y != 4 && guard < 200) begin
            cyc(0, 1, 0, 0);
            guard++;
        end
        chk("t4_top_y", projectile_ypos, 12'd4);
        chk("t4_top_active", {11'd0, bullet_active}, 12'd1);
        cyc(0, 1, 0, 0);
        chk("t4_retire", {11'd0, bullet_active}, 12'd0);
        chk("t4_retire_y", projectile_ypos, 12'd4);
        repeat (9) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t4_cd_fire", {11'd0, bullet_active}, 12'd0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_still_off", {11'd0, bullet_active}, 12'd0);
        cyc(1, 0, 0, 0);
        chk("t4_relaunch", {11'd0, bullet_active}, 12'd1);
        chk("t4_relaunch_shot", {11'd0, shot_fired}, 12'd1);
        $display("step 4 top retire and cooldown: active=%0d", bullet_active);

        // 5: fire held through retirement and cooldown
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        repeat (15) cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
`ifdef PROJECTILE_AUTOFIRE_EN
        chk("t5_autofire", {11'd0, bullet_active}, 12'd1);
`else
        chk("t5_no_relaunch", {11'd0, bullet_active}, 12'd0);
`endif
        $display("step 5 held fire: active=%0d", bullet_active);

        // 6: reset mid-flight
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t6_flying", {11'd0, bullet_active}, 12'd1);
        cyc(1, 0, 0, 1);
        chk("t6_active", {11'd0, bullet_active}, 12'd0);
        chk("t6_x", projectile_xpos, 12'd0);
        chk("t6_y", projectile_ypos, 12'd0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t6_idle_launch", {11'd0, bullet_active}, 12'd1);
        $display("step 6 reset mid-flight: relaunch active=%0d", bullet_active);

        // Random traffic against the model
        f = 0;
        for (int i = 0; i < 4000; i++) begin
            player_xpos = ($urandom_range(0, 7) == 0) ? 12'(4095 - $urandom_range(0, 30))
                                                      : 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) f = ~f;
            cyc(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 699) == 0));
        end
        $display("random phase: %0d cycles", 4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
